// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: ALU codes, opcode/funct
// constants, FSM states and the registered instruction class.
package mips_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t op_nop = 4'd0;
    localparam alu_op_t op_add = 4'd1;
    localparam alu_op_t op_sub = 4'd2;
    localparam alu_op_t op_and = 4'd3;
    localparam alu_op_t op_or  = 4'd4;
    localparam alu_op_t op_xor = 4'd5;
    localparam alu_op_t op_nor = 4'd6;
    localparam alu_op_t op_slt = 4'd7;
    localparam alu_op_t op_sll = 4'd8;
    localparam alu_op_t op_srl = 4'd9;
    localparam alu_op_t op_beq = 4'd10;
    localparam alu_op_t op_bne = 4'd11;

    localparam logic [5:0] opc_rtype = 6'h00;
    localparam logic [5:0] opc_j     = 6'h02;
    localparam logic [5:0] opc_jal   = 6'h03;
    localparam logic [5:0] opc_beq   = 6'h04;
    localparam logic [5:0] opc_bne   = 6'h05;
    localparam logic [5:0] opc_addi  = 6'h08;
    localparam logic [5:0] opc_slti  = 6'h0A;
    localparam logic [5:0] opc_andi  = 6'h0C;
    localparam logic [5:0] opc_lh    = 6'h21;
    localparam logic [5:0] opc_lw    = 6'h23;
    localparam logic [5:0] opc_sh    = 6'h29;
    localparam logic [5:0] opc_sw    = 6'h2B;

    localparam logic [5:0] fn_sll  = 6'h00;
    localparam logic [5:0] fn_srl  = 6'h02;
    localparam logic [5:0] fn_jr   = 6'h08;
    localparam logic [5:0] fn_jalr = 6'h09;
    localparam logic [5:0] fn_add  = 6'h20;
    localparam logic [5:0] fn_sub  = 6'h22;
    localparam logic [5:0] fn_and  = 6'h24;
    localparam logic [5:0] fn_or   = 6'h25;
    localparam logic [5:0] fn_xor  = 6'h26;
    localparam logic [5:0] fn_nor  = 6'h27;
    localparam logic [5:0] fn_slt  = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU, CLS_IMM, CLS_BRANCH, CLS_JUMP, CLS_JAL, CLS_JR, CLS_JALR,
        CLS_LOAD, CLS_LOAD_H, CLS_STORE, CLS_STORE_H
    } instr_class_t;

    function automatic logic is_load(instr_class_t c);
        return (c == CLS_LOAD) || (c == CLS_LOAD_H);
    endfunction

    function automatic logic is_store(instr_class_t c);
        return (c == CLS_STORE) || (c == CLS_STORE_H);
    endfunction

    function automatic logic is_half(instr_class_t c);
        return (c == CLS_LOAD_H) || (c == CLS_STORE_H);
    endfunction

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction decoder: opcode/funct to class, ALU code and legality.
module mips_decode
    import mips_pkg::*;
#(
    parameter int HALF_EN = 1
) (
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output alu_op_t      alu_op,
    output logic         valid
);

    always_comb begin
        cls    = CLS_ALU;
        alu_op = op_nop;
        valid  = 1'b1;
        case (opcode)
            opc_rtype: begin
                case (funct)
                    fn_add:  alu_op = op_add;
                    fn_sub:  alu_op = op_sub;
                    fn_and:  alu_op = op_and;
                    fn_or:   alu_op = op_or;
                    fn_xor:  alu_op = op_xor;
                    fn_nor:  alu_op = op_nor;
                    fn_slt:  alu_op = op_slt;
                    fn_sll:  alu_op = op_sll;
                    fn_srl:  alu_op = op_srl;
                    fn_jr:   cls = CLS_JR;
                    fn_jalr: cls = CLS_JALR;
                    default: valid = 1'b0;
                endcase
            end
            opc_addi: begin cls = CLS_IMM;    alu_op = op_add; end
            opc_andi: begin cls = CLS_IMM;    alu_op = op_and; end
            opc_slti: begin cls = CLS_IMM;    alu_op = op_slt; end
            opc_beq:  begin cls = CLS_BRANCH; alu_op = op_beq; end
            opc_bne:  begin cls = CLS_BRANCH; alu_op = op_bne; end
            opc_j:    cls = CLS_JUMP;
            opc_jal:  cls = CLS_JAL;
            opc_lw:   begin cls = CLS_LOAD;   alu_op = op_add; end
            opc_sw:   begin cls = CLS_STORE;  alu_op = op_add; end
            opc_lh:   begin cls = CLS_LOAD_H;  alu_op = op_add; valid = (HALF_EN != 0); end
            opc_sh:   begin cls = CLS_STORE_H; alu_op = op_add; valid = (HALF_EN != 0); end
            default:  valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM sequencing fetch/decode/execute/memory/writeback
// over a request/ready memory port, with timeout and illegal-instruction traps.
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int HALF_EN     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_half,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_imm,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               jump,
    output logic               branch,
    output logic               jal,
    output logic               jr,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               busy,
    output logic               illegal,
    output logic               bus_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t       state, state_next;
    instr_class_t cls_q, dec_cls;
    alu_op_t      alu_q, dec_alu, alu_sel;
    logic         dec_valid;
    logic [CNT_W-1:0] wait_cnt;
    logic         in_wait, entering_wait, timeout_hit;

    mips_decode #(.HALF_EN(HALF_EN)) u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (dec_cls),
        .alu_op (dec_alu),
        .valid  (dec_valid)
    );

    assign in_wait       = (state == ST_FETCH) || (state == ST_MEM);
    assign entering_wait = (state_next != state) &&
                           ((state_next == ST_FETCH) || (state_next == ST_MEM));
    // Expiry only when ready is still low; a completing access wins the tie.
    assign timeout_hit   = (MEM_TIMEOUT != 0) && in_wait && !mem_ready &&
                           (wait_cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:  if (mem_ready) state_next = ST_DECODE;
                       else if (timeout_hit) state_next = ST_TRAP;
            ST_DECODE: state_next = dec_valid ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                case (cls_q)
                    CLS_ALU, CLS_IMM, CLS_JAL, CLS_JALR:         state_next = ST_WB;
                    CLS_LOAD, CLS_LOAD_H, CLS_STORE, CLS_STORE_H: state_next = ST_MEM;
                    default:                                     state_next = ST_FETCH;
                endcase
            end
            ST_MEM:    if (mem_ready) state_next = is_load(cls_q) ? ST_WB : ST_FETCH;
                       else if (timeout_hit) state_next = ST_TRAP;
            ST_WB:     state_next = ST_FETCH;
            default:   state_next = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q    <= CLS_ALU;
            alu_q    <= op_nop;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if (state == ST_DECODE) begin
                cls_q <= dec_cls;
                alu_q <= dec_alu;
                if (!dec_valid) illegal <= 1'b1;
            end
            if (timeout_hit) bus_err <= 1'b1;
            if (entering_wait)
                wait_cnt <= '0;
            else if (in_wait && !mem_ready && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Enables are gated by rst_n so an in-flight request drops as soon as reset asserts.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_half   = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_imm    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        jal        = 1'b0;
        jr         = 1'b0;
        alu_sel    = op_nop;
        busy       = (state != ST_TRAP);
        if (rst_n) begin
            case (state)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                ST_EXEC: begin
                    alu_sel = alu_q;
                    reg_imm = (cls_q == CLS_IMM) || is_load(cls_q) || is_store(cls_q);
                    branch  = (cls_q == CLS_BRANCH);
                    jump    = (cls_q == CLS_JUMP) || (cls_q == CLS_JAL);
                    jal     = (cls_q == CLS_JAL) || (cls_q == CLS_JALR);
                    jr      = (cls_q == CLS_JR) || (cls_q == CLS_JALR);
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    alu_sel  = op_add;
                    reg_imm  = 1'b1;
                    mem_we   = is_store(cls_q);
                    mem_half = is_half(cls_q);
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_load(cls_q);
                    jal        = (cls_q == CLS_JAL) || (cls_q == CLS_JALR);
                    jr         = (cls_q == CLS_JALR);
                end
                default: ;
            endcase
        end
    end

    assign alu_op = ALUOP_W'(alu_sel);

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench: random instruction stream with random memory waits, checked
// cycle by cycle against a phase-level model built from an instruction property table.
module tb_mips_mc_controller;

    localparam int TO = 4;

    typedef struct packed {
        logic       mem_req, mem_we, mem_half, iord, ir_write, pc_write, reg_imm,
                    mem_to_reg, reg_write, jump, branch, jal, jr, busy, illegal, bus_err;
        logic [3:0] alu_op;
    } ov_t;

    typedef struct {
        string      name;
        logic [5:0] op, fn;
        logic [3:0] alu;
        bit imm, ld, st, half, br, jmp, lnk, jreg, wr;
    } ins_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic a_mem_req, a_mem_we, a_mem_half, a_iord, a_ir_write, a_pc_write, a_reg_imm,
          a_mem_to_reg, a_reg_write, a_jump, a_branch, a_jal, a_jr, a_busy, a_illegal, a_bus_err;
    logic [3:0] a_alu_op;

    logic       rst_nb = 1'b0, ready_b = 1'b0;
    logic [5:0] opcode_b = '0, funct_b = '0;
    logic b_mem_req, b_mem_we, b_mem_half, b_iord, b_ir_write, b_pc_write, b_reg_imm,
          b_mem_to_reg, b_reg_write, b_jump, b_branch, b_jal, b_jr, b_busy, b_illegal, b_bus_err;
    logic [3:0] b_alu_op;

    mips_mc_controller #(.ALUOP_W(4), .MEM_TIMEOUT(TO), .HALF_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_half(a_mem_half), .iord(a_iord),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_imm(a_reg_imm),
        .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write), .jump(a_jump), .branch(a_branch),
        .jal(a_jal), .jr(a_jr), .alu_op(a_alu_op), .busy(a_busy), .illegal(a_illegal),
        .bus_err(a_bus_err)
    );

    mips_mc_controller #(.ALUOP_W(4), .MEM_TIMEOUT(0), .HALF_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_nb), .opcode(opcode_b), .funct(funct_b), .mem_ready(ready_b),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_half(b_mem_half), .iord(b_iord),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_imm(b_reg_imm),
        .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write), .jump(b_jump), .branch(b_branch),
        .jal(b_jal), .jr(b_jr), .alu_op(b_alu_op), .busy(b_busy), .illegal(b_illegal),
        .bus_err(b_bus_err)
    );

    ov_t got_a, got_b;
    assign got_a = {a_mem_req, a_mem_we, a_mem_half, a_iord, a_ir_write, a_pc_write, a_reg_imm,
                    a_mem_to_reg, a_reg_write, a_jump, a_branch, a_jal, a_jr, a_busy, a_illegal,
                    a_bus_err, a_alu_op};
    assign got_b = {b_mem_req, b_mem_we, b_mem_half, b_iord, b_ir_write, b_pc_write, b_reg_imm,
                    b_mem_to_reg, b_reg_write, b_jump, b_branch, b_jal, b_jr, b_busy, b_illegal,
                    b_bus_err, b_alu_op};

    int   checks = 0;
    int   errors = 0;
    ins_t tbl[$];

    task automatic check(input string tag, input ov_t got, input ov_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Flag letters: i=immediate, l=load, s=store, h=half, b=branch, j=jump, k=link, r=jr, w=writes reg
    function automatic void def(string nm, int op, int fn, int alu, string f);
        ins_t t;
        t.name = nm; t.op = 6'(op); t.fn = 6'(fn); t.alu = 4'(alu);
        t.imm = 0; t.ld = 0; t.st = 0; t.half = 0; t.br = 0;
        t.jmp = 0; t.lnk = 0; t.jreg = 0; t.wr = 0;
        for (int i = 0; i < f.len(); i++) begin
            case (f[i])
                "i": t.imm = 1;  "l": t.ld = 1;   "s": t.st = 1;  "h": t.half = 1;
                "b": t.br = 1;   "j": t.jmp = 1;  "k": t.lnk = 1; "r": t.jreg = 1;
                "w": t.wr = 1;
                default: ;
            endcase
        end
        tbl.push_back(t);
    endfunction

    function automatic ins_t by_name(string nm);
        foreach (tbl[i]) if (tbl[i].name == nm) return tbl[i];
        return tbl[0];
    endfunction

    function automatic ov_t idle();
        ov_t e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    task automatic cyc(input bit sel_b, input logic rdy, input ov_t e, input string tag);
        if (sel_b) ready_b = rdy; else mem_ready = rdy;
        @(negedge clk);
        check(tag, sel_b ? got_b : got_a, e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("reset", got_a, idle());
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Up to wf/wm not-ready cycles precede the completing cycle of each access.
    task automatic run_ins(input ins_t t, input int wf, input int wm);
        ov_t e;
        opcode = t.op; funct = t.fn;
        for (int i = 0; i <= wf; i++) begin
            e = idle(); e.mem_req = 1;
            if (i == wf) begin e.ir_write = 1; e.pc_write = 1; end
            cyc(0, (i == wf), e, {t.name, ".fetch"});
        end
        cyc(0, 1'($urandom_range(0, 1)), idle(), {t.name, ".decode"});
        e = idle();
        e.alu_op = t.alu; e.reg_imm = t.imm; e.branch = t.br;
        e.jump = t.jmp; e.jal = t.lnk; e.jr = t.jreg;
        cyc(0, 1'($urandom_range(0, 1)), e, {t.name, ".exec"});
        if (t.ld || t.st) begin
            for (int i = 0; i <= wm; i++) begin
                e = idle(); e.mem_req = 1; e.iord = 1; e.alu_op = 4'd1; e.reg_imm = 1;
                e.mem_we = t.st; e.mem_half = t.half;
                cyc(0, (i == wm), e, {t.name, ".mem"});
            end
        end
        if (t.wr) begin
            e = idle(); e.reg_write = 1; e.mem_to_reg = t.ld; e.jal = t.lnk; e.jr = t.jreg;
            cyc(0, 1'($urandom_range(0, 1)), e, {t.name, ".wb"});
        end
    endtask

    initial begin
        ov_t e;
        def("add", 'h00, 'h20, 1, "w");   def("sub", 'h00, 'h22, 2, "w");
        def("and", 'h00, 'h24, 3, "w");   def("or",  'h00, 'h25, 4, "w");
        def("xor", 'h00, 'h26, 5, "w");   def("nor", 'h00, 'h27, 6, "w");
        def("slt", 'h00, 'h2A, 7, "w");   def("sll", 'h00, 'h00, 8, "w");
        def("srl", 'h00, 'h02, 9, "w");   def("jr",  'h00, 'h08, 0, "r");
        def("jalr", 'h00, 'h09, 0, "rkw");
        def("addi", 'h08, 0, 1, "iw");    def("andi", 'h0C, 0, 3, "iw");
        def("slti", 'h0A, 0, 7, "iw");
        def("beq", 'h04, 0, 10, "b");     def("bne", 'h05, 0, 11, "b");
        def("lw",  'h23, 0, 1, "ilw");    def("sw",  'h2B, 0, 1, "is");
        def("lh",  'h21, 0, 1, "ilhw");   def("sh",  'h29, 0, 1, "ish");
        def("j",   'h02, 0, 0, "j");      def("jal", 'h03, 0, 0, "jkw");

        reset_a();
        run_ins(by_name("add"), 0, 0);
        run_ins(by_name("lw"), 0, 2);
        run_ins(by_name("sh"), 0, 0);
        run_ins(by_name("jal"), 0, 0);
        run_ins(by_name("beq"), 0, 0);
        run_ins(by_name("slt"), 1, 0);
        for (int n = 0; n < 80; n++)
            run_ins(tbl[$urandom_range(0, tbl.size() - 1)], $urandom_range(0, TO), $urandom_range(0, TO));

        // Unknown R-type funct traps after DECODE and stays trapped.
        opcode = 6'h00; funct = 6'h3F;
        e = idle(); e.mem_req = 1; e.ir_write = 1; e.pc_write = 1;
        cyc(0, 1, e, "illfn.fetch");
        cyc(0, 1, idle(), "illfn.decode");
        e = '0; e.illegal = 1;
        for (int i = 0; i < 3; i++) cyc(0, 1'($urandom_range(0, 1)), e, "illfn.trap");

        // Reset in the middle of a store's memory wait abandons the access.
        reset_a();
        opcode = 6'h2B; funct = 6'h00;
        e = idle(); e.mem_req = 1; e.ir_write = 1; e.pc_write = 1;
        cyc(0, 1, e, "swrst.fetch");
        cyc(0, 0, idle(), "swrst.decode");
        e = idle(); e.alu_op = 4'd1; e.reg_imm = 1;
        cyc(0, 0, e, "swrst.exec");
        e = idle(); e.mem_req = 1; e.iord = 1; e.alu_op = 4'd1; e.reg_imm = 1; e.mem_we = 1;
        cyc(0, 0, e, "swrst.mem");
        rst_n = 1'b0;
        #1 check("swrst.rst_now", got_a, idle());
        @(negedge clk);
        check("swrst.rst_cycle", got_a, idle());
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_ins(by_name("add"), 0, 0);

        // Fetch timeout: TO waits are tolerated, the next not-ready cycle expires.
        reset_a();
        opcode = 6'h00; funct = 6'h20;
        e = idle(); e.mem_req = 1;
        for (int i = 0; i <= TO; i++) cyc(0, 0, e, "tmo.fetch");
        e = '0; e.bus_err = 1;
        for (int i = 0; i < 3; i++) cyc(0, 1'($urandom_range(0, 1)), e, "tmo.trap");
        reset_a();
        run_ins(by_name("add"), 0, 0);

        // Second instance: timeout disabled, halfword ops illegal.
        rst_nb = 1'b0; ready_b = 1'b0;
        @(negedge clk);
        check("b.reset", got_b, idle());
        @(posedge clk);
        #1 rst_nb = 1'b1;
        opcode_b = 6'h29; funct_b = 6'h00;
        e = idle(); e.mem_req = 1;
        for (int i = 0; i < 300; i++) cyc(1, 0, e, "b.nowait_limit");
        e.ir_write = 1; e.pc_write = 1;
        cyc(1, 1, e, "b.fetch");
        cyc(1, 1, idle(), "b.decode");
        e = '0; e.illegal = 1;
        for (int i = 0; i < 2; i++) cyc(1, 1, e, "b.sh_trap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit for the MIPS core: replaces single-cycle decode with a state machine that sequences FETCH/DECODE/EXEC/MEM/WB over a shared variable-latency memory port. Decodes the same R/I/J instruction set (add, sub, and, or, xor, nor, slt, sll, srl, jr, jalr, addi, andi, slti, beq, bne, lw, sw, lh, sh, j, jal). Adds a request/ready memory handshake, a bounded memory timeout, and illegal-instruction trapping. Sits between the IR/PC datapath registers and the ALU, register-file and memory enables.

## Interface
- ALUOP_W, 4: width of alu_op (≥4).
- MEM_TIMEOUT, 255: max wait cycles for mem_ready per access; 0 disables timeout.
- HALF_EN, 1: 1 decodes lh/sh; 0 treats them as illegal.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], stable from DECODE until the next FETCH completes
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write access (valid with mem_req)
- mem_half  out  1  halfword access (lh/sh)
- iord  out  1  address select: 0 = PC, 1 = ALU result
- ir_write, pc_write  out  1  load IR / PC+4 on fetch completion
- reg_imm, mem_to_reg, reg_write, jump, branch, jal, jr  out  1  datapath selects and enables
- alu_op  out  ALUOP_W  ALU operation code
- busy  out  1  high in every state except TRAP
- illegal, bus_err  out  1  sticky trap causes

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset → FETCH. Every output is 0 during reset, except busy, which is 1.
- FETCH: mem_req=1 and iord=0. When mem_ready=1, assert ir_write=1 and pc_write=1 in the same cycle (Mealy), then → DECODE. Otherwise hold.
- DECODE: register the instruction class and alu_op from opcode/funct.
  - Unlisted opcode or R-type funct → TRAP with illegal=1.
  - lh/sh with HALF_EN=0 → TRAP with illegal=1.
  - Otherwise → EXEC.
- EXEC: drive alu_op and reg_imm (1 for addi, andi, slti, lw, sw, lh, sh).
  - R-type ALU ops and immediate ALU ops → WB.
  - beq/bne: branch=1, alu_op = op_beq/op_bne, → FETCH.
  - j: jump=1, → FETCH.
  - jal: jump=1 and jal=1, → WB.
  - jr: jr=1, → FETCH.
  - jalr: jr=1 and jal=1, → WB.
  - Loads and stores: alu_op=op_add, → MEM.
- MEM: mem_req=1, iord=1, alu_op=op_add, reg_imm=1. mem_we=1 for sw/sh; mem_half=1 for lh/sh. On mem_ready, stores → FETCH and loads → WB.
- WB: reg_write=1 for exactly one cycle. mem_to_reg=1 for loads. jal/jr hold their EXEC values. Then → FETCH.
- slt asserts only alu_op=op_slt and reg_write; it never asserts branch.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0. If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0 → TRAP with bus_err=1. mem_ready=1 in the same cycle as expiry wins: no trap.
- TRAP: every enable is 0 and busy=0. TRAP is left only by reset. illegal and bus_err hold until reset.
- Asserting rst_n mid-access drops mem_req immediately; the in-flight access is abandoned.
- Outputs not named for a state are 0 in that state.

## Timing
- Zero-wait memory (mem_ready high in the request cycle):
  - beq/bne/j/jr: 3 cycles.
  - R-type, immediate ALU ops, jal, jalr, sw, sh: 4 cycles.
  - lw, lh: 5 cycles.
- Each mem_ready=0 cycle in FETCH or MEM adds one cycle.
- Controller outputs come from registered state and class, plus mem_ready for ir_write/pc_write and the FETCH/MEM exits. No combinational path from opcode/funct to outputs.
- Wait counter width is $clog2(MEM_TIMEOUT+1), minimum 1. It saturates and never wraps.

## Structure
- Shared package mips_pkg holds:
  - ALU opcode constants: op_nop=0, op_add=1, op_sub=2, op_and=3, op_or=4, op_xor=5, op_nor=6, op_slt=7, op_sll=8, op_srl=9, op_beq=10, op_bne=11.
  - Opcode and funct constants.
  - The state enum and the instruction-class enum.
- One sub-module, mips_decode: combinational opcode/funct → {class, alu_op, valid}. It is instantiated once and its outputs are registered in DECODE.

## Test plan
- add (op 0x00, funct 0x20), mem_ready tied 1 → alu_op=1 in EXEC; reg_write pulses exactly once in cycle 4; next mem_req at cycle 5.
- lw (0x23), 2 wait states in MEM → mem_req and iord high for 3 MEM cycles; mem_to_reg and reg_write in WB; total 7 cycles.
- sh (0x29) with HALF_EN=1 → mem_we=1 and mem_half=1 in MEM, no reg_write. Same opcode with HALF_EN=0 → illegal=1, busy=0 after DECODE.
- jal (0x03) → jump=1 and jal=1 in EXEC; reg_write=1 and jal=1 in WB; 4 cycles. beq (0x04) → branch=1 and alu_op=10 for one cycle; 3 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → bus_err=1 after 4 wait cycles; state stuck in TRAP; rst_n pulse returns to FETCH with mem_req=1.
- Unknown funct 0x3F, and rst_n asserted mid-MEM of a sw → illegal trap; on reset all enables are 0 within the reset cycle.
